deposit_tally: RTL and testbench

- Upstream of the LCD display wrapper in the return-and-earn machine.
- Counts accepted 250 mL and 500 mL containers plus their sum, and tracks the session done and error flags.
- Presents each count as three BCD digits through a single shared sequential double-dabble converter that services the three counters round-robin.
- Outputs drive the display's hundreds/tens/ones (total), *_250, *_500, done and error inputs directly.

---
 rtl/deposit_tally_if.sv | 31 +++
 rtl/deposit_tally.sv | 141 ++++++++++++++
 tb/tb_deposit_tally.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/deposit_tally_if.sv
// Item-pulse inputs and display-side outputs of the deposit tally.
interface deposit_tally_if;
    logic       item_250;
    logic       item_500;
    logic       item_reject;
    logic       finish;
    logic [3:0] hundreds, tens, ones;
    logic [3:0] hundreds_250, tens_250, ones_250;
    logic [3:0] hundreds_500, tens_500, ones_500;
    logic       done;
    logic       error;
    logic       refresh;

    // Source of item pulses / consumer of the digits (bench side).
    modport master (
        output item_250, item_500, item_reject, finish,
        input  hundreds, tens, ones,
        input  hundreds_250, tens_250, ones_250,
        input  hundreds_500, tens_500, ones_500,
        input  done, error, refresh
    );

    // The tally itself.
    modport slave (
        input  item_250, item_500, item_reject, finish,
        output hundreds, tens, ones,
        output hundreds_250, tens_250, ones_250,
        output hundreds_500, tens_500, ones_500,
        output done, error, refresh
    );
endinterface

// File: rtl/deposit_tally.sv
// Container tally: three saturating counters, sticky done/error flags and a
// single shared double-dabble converter sweeping total -> 250 -> 500.
module deposit_tally #(
    parameter int CNT_W     = 10,
    parameter int MAX_COUNT = 999
) (
    input  logic            CLOCK_50,
    input  logic            rst,
    deposit_tally_if.slave  bus
);
    localparam int BW = $clog2(CNT_W);

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_COMMIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_tot_q, cnt_tot_d;
    logic [CNT_W-1:0] cnt_250_q, cnt_250_d;
    logic [CNT_W-1:0] cnt_500_q, cnt_500_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] sh_q;
    logic [11:0]      bcd_q;
    logic [BW-1:0]    bit_q;
    logic [1:0]       ch_q;
    logic [11:0]      dig_tot_q, dig_250_q, dig_500_q;
    logic             refresh_q;
    logic             load_en, shift_en, commit_en;
    logic [CNT_W-1:0] snap;
    logic [11:0]      adj;
    logic             inc_250, inc_500;

    // Counter and flag next-state; everything freezes once the session is done.
    always_comb begin
        inc_250   = !done_q && bus.item_250 && !bus.item_500 && !bus.item_reject;
        inc_500   = !done_q && bus.item_500 && !bus.item_250 && !bus.item_reject;
        cnt_tot_d = cnt_tot_q;
        cnt_250_d = cnt_250_q;
        cnt_500_d = cnt_500_q;
        if (inc_250 && cnt_250_q != CNT_W'(MAX_COUNT)) cnt_250_d = cnt_250_q + 1'b1;
        if (inc_500 && cnt_500_q != CNT_W'(MAX_COUNT)) cnt_500_d = cnt_500_q + 1'b1;
        if ((inc_250 || inc_500) && cnt_tot_q != CNT_W'(MAX_COUNT))
            cnt_tot_d = cnt_tot_q + 1'b1;
        error_d = error_q ||
                  (!done_q && (bus.item_reject || (bus.item_250 && bus.item_500)));
        done_d  = done_q || bus.finish;
    end

    // Counter and flag registers.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            cnt_tot_q <= '0;
            cnt_250_q <= '0;
            cnt_500_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            cnt_tot_q <= cnt_tot_d;
            cnt_250_q <= cnt_250_d;
            cnt_500_q <= cnt_500_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Converter state register.
    always_ff @(posedge CLOCK_50) begin
        if (rst) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    // Converter next state: LOAD -> CNT_W x SHIFT -> COMMIT -> LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   state_d = S_SHIFT;
            S_SHIFT:  if (bit_q == '0) state_d = S_COMMIT;
            S_COMMIT: state_d = S_LOAD;
            default:  state_d = S_LOAD;
        endcase
    end

    // Converter datapath strobes decoded from state.
    always_comb begin
        load_en   = (state_q == S_LOAD);
        shift_en  = (state_q == S_SHIFT);
        commit_en = (state_q == S_COMMIT);
    end

    // Channel select for the snapshot, and the add-3 step on each BCD digit.
    always_comb begin
        case (ch_q)
            2'd1:    snap = cnt_250_q;
            2'd2:    snap = cnt_500_q;
            default: snap = cnt_tot_q;
        endcase
        adj = bcd_q;
        for (int d = 0; d < 3; d++)
            if (bcd_q[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end

    // Converter datapath; digit triples only change here, on commit.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sh_q      <= '0;
            bcd_q     <= '0;
            bit_q     <= '0;
            ch_q      <= 2'd0;
            dig_tot_q <= '0;
            dig_250_q <= '0;
            dig_500_q <= '0;
            refresh_q <= 1'b0;
        end else begin
            refresh_q <= commit_en && (ch_q == 2'd2);
            if (load_en) begin
                sh_q  <= snap;
                bcd_q <= '0;
                bit_q <= BW'(CNT_W - 1);
            end
            if (shift_en) begin
                bcd_q <= {adj[10:0], sh_q[CNT_W-1]};
                sh_q  <= {sh_q[CNT_W-2:0], 1'b0};
                bit_q <= bit_q - 1'b1;
            end
            if (commit_en) begin
                case (ch_q)
                    2'd1:    dig_250_q <= bcd_q;
                    2'd2:    dig_500_q <= bcd_q;
                    default: dig_tot_q <= bcd_q;
                endcase
                ch_q <= (ch_q == 2'd2) ? 2'd0 : ch_q + 1'b1;
            end
        end
    end

    assign {bus.hundreds,     bus.tens,     bus.ones}     = dig_tot_q;
    assign {bus.hundreds_250, bus.tens_250, bus.ones_250} = dig_250_q;
    assign {bus.hundreds_500, bus.tens_500, bus.ones_500} = dig_500_q;
    assign bus.done    = done_q;
    assign bus.error   = error_q;
    assign bus.refresh = refresh_q;
endmodule

// File: tb/tb_deposit_tally.sv
// Directed bench for deposit_tally.
module tb_deposit_tally;
    logic CLOCK_50 = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    deposit_tally_if bus();

    deposit_tally #(.CNT_W(10), .MAX_COUNT(999)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin @(posedge CLOCK_50); #1; end
    endtask

    task automatic pulse(input logic a, input logic b, input logic r, input logic f);
        bus.item_250 = a; bus.item_500 = b; bus.item_reject = r; bus.finish = f;
        @(posedge CLOCK_50); #1;
        bus.item_250 = 0; bus.item_500 = 0; bus.item_reject = 0; bus.finish = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge CLOCK_50); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n, pulses, gap;
        do_reset();
        total++;
        if ({bus.hundreds, bus.tens, bus.ones, bus.hundreds_250, bus.tens_250, bus.ones_250,
             bus.hundreds_500, bus.tens_500, bus.ones_500} !== 36'h0) begin
            bad++; $display("FAIL reset_digits got=%h exp=0", {bus.hundreds, bus.tens, bus.ones,
                bus.hundreds_250, bus.tens_250, bus.ones_250, bus.hundreds_500, bus.tens_500, bus.ones_500});
        end
        total++;
        if ({bus.done, bus.error, bus.refresh} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {bus.done, bus.error, bus.refresh});
        end
        pulses = 0; n = 0;
        for (int i = 1; i <= 40; i++) begin
            idle(1);
            if (bus.refresh === 1'b1) begin pulses++; n = i; end
        end
        total++;
        if (pulses != 1 || n != 36) begin
            bad++; $display("FAIL reset_first_refresh got pulses=%0d at=%0d exp 1 at 36", pulses, n);
        end
        gap = 0;
        for (int i = 1; i <= 100; i++) begin
            idle(1);
            if (bus.refresh === 1'b1) begin gap = i + 4; break; end
        end
        total++;
        if (gap != 36) begin
            bad++; $display("FAIL refresh_period got=%0d exp=36", gap);
        end
        total++;
        if ({bus.hundreds, bus.tens, bus.ones, bus.done, bus.error} !== 14'h0) begin
            bad++; $display("FAIL idle_state got=%h exp=0", {bus.hundreds, bus.tens, bus.ones, bus.done, bus.error});
        end
    endtask

    task automatic test_counts();
        do_reset();
        repeat (3) begin pulse(1, 0, 0, 0); idle(1); end
        repeat (2) begin pulse(0, 1, 0, 0); idle(2); end
        idle(48);
        total++;
        if ({bus.hundreds, bus.tens, bus.ones} !== 12'h005) begin
            bad++; $display("FAIL counts_total got=%h exp=005", {bus.hundreds, bus.tens, bus.ones});
        end
        total++;
        if ({bus.hundreds_250, bus.tens_250, bus.ones_250} !== 12'h003) begin
            bad++; $display("FAIL counts_250 got=%h exp=003", {bus.hundreds_250, bus.tens_250, bus.ones_250});
        end
        total++;
        if ({bus.hundreds_500, bus.tens_500, bus.ones_500} !== 12'h002) begin
            bad++; $display("FAIL counts_500 got=%h exp=002", {bus.hundreds_500, bus.tens_500, bus.ones_500});
        end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (1002) begin pulse(0, 1, 0, 0); idle(1); end
        idle(48);
        total++;
        if ({bus.hundreds_500, bus.tens_500, bus.ones_500} !== 12'h999) begin
            bad++; $display("FAIL sat_500 got=%h exp=999", {bus.hundreds_500, bus.tens_500, bus.ones_500});
        end
        total++;
        if ({bus.hundreds, bus.tens, bus.ones} !== 12'h999) begin
            bad++; $display("FAIL sat_total got=%h exp=999", {bus.hundreds, bus.tens, bus.ones});
        end
        total++;
        if ({bus.hundreds_250, bus.tens_250, bus.ones_250, bus.error} !== 13'h0) begin
            bad++; $display("FAIL sat_250_err got=%h exp=0", {bus.hundreds_250, bus.tens_250, bus.ones_250, bus.error});
        end
    endtask

    task automatic test_error();
        do_reset();
        pulse(1, 1, 0, 0); idle(2);
        pulse(0, 0, 1, 0); idle(2);
        pulse(1, 0, 1, 0); idle(2);
        idle(48);
        total++;
        if ({bus.hundreds, bus.tens, bus.ones, bus.hundreds_250, bus.tens_250, bus.ones_250,
             bus.hundreds_500, bus.tens_500, bus.ones_500} !== 36'h0) begin
            bad++; $display("FAIL err_counts got=%h exp=0", {bus.hundreds, bus.tens, bus.ones,
                bus.hundreds_250, bus.tens_250, bus.ones_250, bus.hundreds_500, bus.tens_500, bus.ones_500});
        end
        total++;
        if (bus.error !== 1'b1) begin
            bad++; $display("FAIL err_set got=%b exp=1", bus.error);
        end
        idle(100);
        total++;
        if (bus.error !== 1'b1) begin
            bad++; $display("FAIL err_sticky got=%b exp=1", bus.error);
        end
    endtask

    task automatic test_finish();
        do_reset();
        pulse(1, 0, 0, 1); idle(1);
        repeat (5) begin pulse(1, 0, 0, 0); idle(1); end
        pulse(0, 0, 1, 0);
        idle(48);
        total++;
        if ({bus.hundreds_250, bus.tens_250, bus.ones_250} !== 12'h001) begin
            bad++; $display("FAIL fin_250 got=%h exp=001", {bus.hundreds_250, bus.tens_250, bus.ones_250});
        end
        total++;
        if ({bus.hundreds, bus.tens, bus.ones} !== 12'h001) begin
            bad++; $display("FAIL fin_total got=%h exp=001", {bus.hundreds, bus.tens, bus.ones});
        end
        total++;
        if ({bus.done, bus.error} !== 2'b10) begin
            bad++; $display("FAIL fin_flags got=%b exp=10", {bus.done, bus.error});
        end
        do_reset();
        total++;
        if ({bus.done, bus.error, bus.hundreds, bus.tens, bus.ones,
             bus.hundreds_250, bus.tens_250, bus.ones_250} !== 26'h0) begin
            bad++; $display("FAIL fin_rst got=%h exp=0", {bus.done, bus.error, bus.hundreds, bus.tens, bus.ones,
                bus.hundreds_250, bus.tens_250, bus.ones_250});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        repeat (123) begin pulse(1, 0, 0, 0); idle(1); end
        idle(48);
        total++;
        if ({bus.hundreds_250, bus.tens_250, bus.ones_250} !== 12'h123) begin
            bad++; $display("FAIL mid_pre got=%h exp=123", {bus.hundreds_250, bus.tens_250, bus.ones_250});
        end
        // Refresh is visible during LOAD of channel 0; channel 1 shifts 13..22 cycles later.
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.refresh === 1'b1) begin n = 1; break; end
            idle(1);
        end
        total++;
        if (n != 1) begin
            bad++; $display("FAIL mid_refresh_timeout got=0 exp=1");
        end
        idle(17);
        do_reset();
        total++;
        if ({bus.hundreds, bus.tens, bus.ones, bus.hundreds_250, bus.tens_250, bus.ones_250,
             bus.hundreds_500, bus.tens_500, bus.ones_500} !== 36'h0) begin
            bad++; $display("FAIL mid_digits got=%h exp=0", {bus.hundreds, bus.tens, bus.ones,
                bus.hundreds_250, bus.tens_250, bus.ones_250, bus.hundreds_500, bus.tens_500, bus.ones_500});
        end
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            idle(1);
            if (bus.refresh === 1'b1) begin n = i; break; end
        end
        total++;
        if (n != 36) begin
            bad++; $display("FAIL mid_restart got=%0d exp=36", n);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.item_250 = 0; bus.item_500 = 0; bus.item_reject = 0; bus.finish = 0;
        @(posedge CLOCK_50); #1;
        test_reset();
        test_counts();
        test_saturate();
        test_error();
        test_finish();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
